// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access unit.
package mem_pkg;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_B    = 2'b01;
    localparam logic [1:0] ST_H    = 2'b10;
    localparam logic [1:0] ST_W    = 2'b11;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_B    = 3'b001;
    localparam logic [2:0] LD_H    = 3'b010;
    localparam logic [2:0] LD_W    = 3'b011;
    localparam logic [2:0] LD_BU   = 3'b100;
    localparam logic [2:0] LD_HU   = 3'b101;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // A nonzero store code takes precedence over any load code.
    function automatic logic [1:0] access_size(input logic [1:0] st, input logic [2:0] ld);
        logic [1:0] sz;
        sz = SZ_W;
        case (st)
            ST_B: sz = SZ_B;
            ST_H: sz = SZ_H;
            ST_W: sz = SZ_W;
            default: begin
                case (ld)
                    LD_B, LD_BU: sz = SZ_B;
                    LD_H, LD_HU: sz = SZ_H;
                    default:     sz = SZ_W;
                endcase
            end
        endcase
        return sz;
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] addrLo);
        logic ok;
        case (sz)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~addrLo[0];
            default: ok = (addrLo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Store lane replication / byte enables and load lane selection / extension.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  stCode,
    input  logic [1:0]  stAddr,
    input  logic [31:0] stData,
    input  logic [2:0]  ldCode,
    input  logic [1:0]  ldAddr,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] ldData
);

    logic [31:0] repByte;
    logic [31:0] repHalf;
    logic [7:0]  selByte;
    logic [15:0] selHalf;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rep_byte
            assign repByte[gi*8 +: 8] = stData[7:0];
        end
        for (gi = 0; gi < 2; gi++) begin : g_rep_half
            assign repHalf[gi*16 +: 16] = stData[15:0];
        end
    endgenerate

    always_comb begin
        wdata = '0;
        be    = '0;
        case (stCode)
            ST_B: begin
                wdata = repByte;
                be    = 4'b0001 << stAddr;
            end
            ST_H: begin
                wdata = repHalf;
                be    = stAddr[1] ? 4'b1100 : 4'b0011;
            end
            ST_W: begin
                wdata = stData;
                be    = 4'b1111;
            end
            default: ;
        endcase
    end

    // Halfword loads are always aligned here, so addr[1] alone picks the lane.
    always_comb begin
        selByte = rdata[7:0];
        case (ldAddr)
            2'd1:    selByte = rdata[15:8];
            2'd2:    selByte = rdata[23:16];
            2'd3:    selByte = rdata[31:24];
            default: selByte = rdata[7:0];
        endcase
        selHalf = ldAddr[1] ? rdata[31:16] : rdata[15:0];
        case (ldCode)
            LD_B:    ldData = {{24{selByte[7]}}, selByte};
            LD_BU:   ldData = {24'd0, selByte};
            LD_H:    ldData = {{16{selHalf[15]}}, selHalf};
            LD_HU:   ldData = {16'd0, selHalf};
            LD_W:    ldData = rdata;
            default: ldData = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: valid/ready bus master with pipeline stall,
// misalignment drop and request timeout.
module mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int TIMEOUT = 15
)(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       addrM,
    input  logic [31:0]       store_dataM,
    input  logic [1:0]        mem_storeM,
    input  logic [2:0]        mem_loadM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-3:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [CNT_W-1:0] waitCnt;
    logic [2:0]       ldCode;
    logic [1:0]       ldAddr;

    logic        isStore;
    logic        isLoad;
    logic        access;
    logic        aligned;
    logic [31:0] alignWdata;
    logic [3:0]  alignBe;
    logic [31:0] alignLoad;
    logic        unusedAddr;

    assign unusedAddr = ^addrM[31:ADDR_W];

    assign isStore = (mem_storeM != ST_NONE);
    assign isLoad  = (mem_loadM != LD_NONE) && (mem_loadM <= LD_HU);
    assign access  = isStore || isLoad;
    assign aligned = is_aligned(access_size(mem_storeM, mem_loadM), addrM[1:0]);

    // Freeze the pipeline in the very cycle an aligned access shows up.
    assign stall = RST_N && (((state == IDLE) && access && aligned) || (state == REQ));

    mem_align u_align (
        .stCode (mem_storeM),
        .stAddr (addrM[1:0]),
        .stData (store_dataM),
        .ldCode (ldCode),
        .ldAddr (ldAddr),
        .rdata  (dmem_rdata),
        .wdata  (alignWdata),
        .be     (alignBe),
        .ldData (alignLoad)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            waitCnt    <= '0;
            ldCode     <= LD_NONE;
            ldAddr     <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !aligned) begin
                        misalign <= 1'b1;
                        state    <= DONE;
                    end else if (access) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= isStore;
                        dmem_addr  <= addrM[ADDR_W-1:2];
                        dmem_be    <= isStore ? alignBe : 4'b1111;
                        dmem_wdata <= alignWdata;
                        ldCode     <= isStore ? LD_NONE : mem_loadM;
                        ldAddr     <= addrM[1:0];
                        waitCnt    <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // A ready arriving in the last allowed cycle still completes.
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        waitCnt  <= '0;
                        state    <= DONE;
                        if (ldCode != LD_NONE) begin
                            load_data  <= alignLoad;
                            load_valid <= 1'b1;
                        end
                    end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        waitCnt  <= '0;
                        state    <= DONE;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed table-driven bench for mem_access plus wait-state, timeout and reset sequences.
module tb_mem_access;

    logic        CLK;
    logic        RST_N;
    logic [31:0] addrM;
    logic [31:0] store_dataM;
    logic [1:0]  mem_storeM;
    logic [2:0]  mem_loadM;
    logic        dmem_req;
    logic        dmem_we;
    logic [10:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_access #(.ADDR_W(13), .TIMEOUT(15)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .addrM       (addrM),
        .store_dataM (store_dataM),
        .mem_storeM  (mem_storeM),
        .mem_loadM   (mem_loadM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ready  (dmem_ready),
        .stall       (stall),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .misalign    (misalign),
        .bus_err     (bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  st;
        logic [2:0]  ld;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        mis;
        logic        we;
        logic [10:0] daddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        lv;
        logic [31:0] ldata;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_storeM  = 2'b00;
        mem_loadM   = 3'b000;
        addrM       = 32'h0;
        store_dataM = 32'h0;
        dmem_ready  = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        mem_storeM  = v.st;
        mem_loadM   = v.ld;
        addrM       = v.addr;
        store_dataM = v.sdata;
        dmem_rdata  = v.rdata;
        dmem_ready  = 1'b0;
    endtask

    // Called at a negedge with the DUT in IDLE; ready is given in the first REQ cycle.
    task automatic run_vec(input int idx, input vec_t v);
        drive(v);
        #1;
        chk($sformatf("v%0d stall_idle", idx), stall, !v.mis);
        @(posedge CLK);
        @(negedge CLK);
        if (!v.mis) begin
            chk($sformatf("v%0d req", idx), dmem_req, 1);
            chk($sformatf("v%0d we", idx), dmem_we, v.we);
            chk($sformatf("v%0d daddr", idx), dmem_addr, v.daddr);
            chk($sformatf("v%0d be", idx), dmem_be, v.be);
            if (v.we) chk($sformatf("v%0d wdata", idx), dmem_wdata, v.wdata);
            chk($sformatf("v%0d stall_req", idx), stall, 1);
            dmem_ready = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            dmem_ready = 1'b0;
        end
        chk($sformatf("v%0d req_done", idx), dmem_req, 0);
        chk($sformatf("v%0d stall_done", idx), stall, 0);
        chk($sformatf("v%0d misalign", idx), misalign, v.mis);
        chk($sformatf("v%0d load_valid", idx), load_valid, v.lv);
        chk($sformatf("v%0d load_data", idx), load_data, v.ldata);
        chk($sformatf("v%0d bus_err", idx), bus_err, 0);
        // Inputs stay held through DONE; they must not start a new access.
        @(posedge CLK);
        #1 idle_inputs();
        @(negedge CLK);
        chk($sformatf("v%0d req_after", idx), dmem_req, 0);
        chk($sformatf("v%0d pulses_clear", idx), {misalign, load_valid}, 0);
    endtask

    initial begin
        int n;
        vec_t v;

        //           st     ld     addr          sdata         rdata         mis  we   daddr    be       wdata         lv   ldata
        vecs[0]  = '{2'd3, 3'd0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b1, 11'h041, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{2'd1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1'b0, 1'b1, 11'h040, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[2]  = '{2'd2, 3'd0, 32'h0000_0102, 32'h0000_1234, 32'h0,        1'b0, 1'b1, 11'h040, 4'b1100, 32'h1234_1234, 1'b0, 32'h0};
        vecs[3]  = '{2'd0, 3'd1, 32'h0000_0101, 32'h0,         32'h0000_8000, 1'b0, 1'b0, 11'h040, 4'b1111, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[4]  = '{2'd0, 3'd4, 32'h0000_0101, 32'h0,         32'h0000_8000, 1'b0, 1'b0, 11'h040, 4'b1111, 32'h0,        1'b1, 32'h0000_0080};
        vecs[5]  = '{2'd0, 3'd2, 32'h0000_0002, 32'h0,         32'hF00D_0000, 1'b0, 1'b0, 11'h000, 4'b1111, 32'h0,        1'b1, 32'hFFFF_F00D};
        vecs[6]  = '{2'd0, 3'd5, 32'h0000_0002, 32'h0,         32'hF00D_0000, 1'b0, 1'b0, 11'h000, 4'b1111, 32'h0,        1'b1, 32'h0000_F00D};
        vecs[7]  = '{2'd0, 3'd3, 32'h0000_0102, 32'h0,         32'h5555_5555, 1'b1, 1'b0, 11'h000, 4'b0000, 32'h0,        1'b0, 32'h0000_F00D};
        vecs[8]  = '{2'd0, 3'd3, 32'hFFFF_1FFC, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 11'h7FF, 4'b1111, 32'h0,        1'b1, 32'h1234_5678};
        vecs[9]  = '{2'd1, 3'd0, 32'h0000_0001, 32'h0000_005A, 32'h0,        1'b0, 1'b1, 11'h000, 4'b0010, 32'h5A5A_5A5A, 1'b0, 32'h1234_5678};
        vecs[10] = '{2'd2, 3'd0, 32'h0000_0101, 32'h0000_BEEF, 32'h0,        1'b1, 1'b0, 11'h000, 4'b0000, 32'h0,        1'b0, 32'h1234_5678};
        vecs[11] = '{2'd3, 3'd3, 32'h0000_0008, 32'h1122_3344, 32'hFFFF_FFFF, 1'b0, 1'b1, 11'h002, 4'b1111, 32'h1122_3344, 1'b0, 32'h1234_5678};
        vecs[12] = '{2'd2, 3'd0, 32'h0000_0100, 32'h0000_ABCD, 32'h0,        1'b0, 1'b1, 11'h040, 4'b0011, 32'hABCD_ABCD, 1'b0, 32'h1234_5678};
        vecs[13] = '{2'd0, 3'd1, 32'h0000_0003, 32'h0,         32'h7F00_0000, 1'b0, 1'b0, 11'h000, 4'b1111, 32'h0,        1'b1, 32'h0000_007F};
        vecs[14] = '{2'd0, 3'd5, 32'h0000_01FE, 32'h0,         32'h8001_0000, 1'b0, 1'b0, 11'h07F, 4'b1111, 32'h0,        1'b1, 32'h0000_8001};

        RST_N      = 1'b0;
        dmem_rdata = 32'h0;
        idle_inputs();
        repeat (3) @(negedge CLK);
        chk("rst req", dmem_req, 0);
        chk("rst stall", stall, 0);
        chk("rst addr_be_we", {20'd0, dmem_addr, dmem_be, dmem_we}, 0);
        chk("rst wdata", dmem_wdata, 0);
        chk("rst load_data", load_data, 0);
        chk("rst pulses", {load_valid, misalign, bus_err}, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 15; i++) begin
            run_vec(i, vecs[i]);
            $display("vec %0d st=%0d ld=%0d addr=%h -> load_data=%h", i, vecs[i].st, vecs[i].ld,
                     vecs[i].addr, load_data);
        end

        // Reserved load code 110 is not an access.
        mem_loadM = 3'b110;
        addrM     = 32'h0000_0001;
        #1 chk("ld110 stall", stall, 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("ld110 req", dmem_req, 0);
        chk("ld110 misalign", misalign, 0);
        idle_inputs();
        @(negedge CLK);
        $display("seq reserved load code: req=%0d stall=%0d", dmem_req, stall);

        // Ready arrives in the 15th (last allowed) REQ cycle: completes without error.
        v = '{2'd0, 3'd3, 32'h0000_0040, 32'h0, 32'hA1B2_C3D4, 1'b0, 1'b0, 11'h010, 4'b1111, 32'h0, 1'b1, 32'hA1B2_C3D4};
        drive(v);
        @(posedge CLK);
        n = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            if (dmem_req && stall) n++;
        end
        chk("late_ready held", n, 14);
        @(negedge CLK);
        dmem_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        dmem_ready = 1'b0;
        chk("late_ready load_valid", load_valid, 1);
        chk("late_ready bus_err", bus_err, 0);
        chk("late_ready load_data", load_data, 32'hA1B2_C3D4);
        chk("late_ready stall", stall, 0);
        @(posedge CLK);
        #1 idle_inputs();
        @(negedge CLK);
        $display("seq late ready: held=%0d load_data=%h", n, load_data);

        // Ready withheld: abort after 15 REQ cycles.
        v = '{2'd0, 3'd2, 32'h0000_0004, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 11'h001, 4'b1111, 32'h0, 1'b0, 32'h0};
        drive(v);
        @(posedge CLK);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!dmem_req) break;
            n++;
        end
        chk("timeout req_cycles", n, 15);
        chk("timeout bus_err", bus_err, 1);
        chk("timeout stall", stall, 0);
        chk("timeout load_valid", load_valid, 0);
        chk("timeout load_data", load_data, 32'hA1B2_C3D4);
        @(posedge CLK);
        #1 idle_inputs();
        @(negedge CLK);
        chk("timeout bus_err_pulse", bus_err, 0);
        chk("timeout req_after", dmem_req, 0);
        $display("seq timeout: req_cycles=%0d load_data=%h", n, load_data);

        // Reset while the request is outstanding.
        v = '{2'd3, 3'd0, 32'h0000_0010, 32'hCAFE_BABE, 32'h0, 1'b0, 1'b1, 11'h004, 4'b1111, 32'hCAFE_BABE, 1'b0, 32'h0};
        drive(v);
        @(posedge CLK);
        @(negedge CLK);
        chk("rstmid req_before", dmem_req, 1);
        #1 RST_N = 1'b0;
        #1;
        chk("rstmid req", dmem_req, 0);
        chk("rstmid stall", stall, 0);
        chk("rstmid be", dmem_be, 0);
        chk("rstmid load_data", load_data, 0);
        idle_inputs();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rstmid no_completion", {dmem_req, load_valid, bus_err, misalign}, 0);
        $display("seq reset mid-request: req=%0d stall=%0d", dmem_req, stall);

        v = '{2'd0, 3'd3, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 11'h008, 4'b1111, 32'h0, 1'b1, 32'hCAFE_F00D};
        run_vec(99, v);
        $display("seq post-reset load: load_data=%h", load_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
